// File: rtl/seg7_scan_if.sv
// Load/display bundle for the seg7_scan multiplexed display controller.
// The host side drives frames in; the controller side drives the panel.
interface seg7_scan_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   data_in;
    logic                  lz_en;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     an;
    logic                  pending;
    logic                  frame_tick;

    modport master (
        output load, data_in, lz_en,
        input  seg, an, pending, frame_tick
    );

    modport slave (
        input  load, data_in, lz_en,
        output seg, an, pending, frame_tick
    );
endinterface

// File: rtl/seg7_scan.sv
// Time-multiplexed 7-segment scan controller with a shared decoder,
// inter-digit blanking and frame-boundary double buffering.
module seg7 (
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'b0000000;
        unique case (nib)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b1001110;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            4'hF: seg = 7'b1000111;
        endcase
    end
endmodule

module seg7_scan #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    seg7_scan_if.slave  bus
);
    localparam int IW   = $clog2(DIGITS);
    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam int DW   = 4 * DIGITS;

    localparam logic [IW-1:0] ILAST = IW'(DIGITS - 1);
    localparam logic [CW-1:0] BLAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLAST = CW'(REFRESH_DIV - 1);

    typedef enum logic {
        BLANK,
        SHOW
    } state_t;

    state_t          state, nstate;
    logic [CW-1:0]   cnt, ncnt;
    logic [IW-1:0]   idx, nidx;
    logic            run;
    logic            bnd;
    logic [DW-1:0]   shadow, disp;
    logic            pending;
    logic            frame_tick;
    logic [DIGITS-1:0] an, an_n;
    logic [6:0]      seg, seg_n, dec;
    logic [3:0]      nib;
    logic [DIGITS-1:0] zhi;
    logic            acc;
    logic            sup;

    // run is clear only out of reset, forcing the very first edge to be a boundary
    always_comb begin
        nstate = state;
        ncnt   = cnt + CW'(1);
        nidx   = idx;
        bnd    = 1'b0;
        if (!run) begin
            nstate = BLANK;
            ncnt   = '0;
            nidx   = '0;
            bnd    = 1'b1;
        end else begin
            unique case (state)
                BLANK: begin
                    if (cnt == BLAST) begin
                        nstate = SHOW;
                        ncnt   = '0;
                    end
                end
                SHOW: begin
                    if (cnt == SLAST) begin
                        nstate = BLANK;
                        ncnt   = '0;
                        nidx   = (idx == ILAST) ? '0 : idx + IW'(1);
                        bnd    = (idx == ILAST);
                    end
                end
            endcase
        end
    end

    always_comb begin
        nib = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (IW'(k) == nidx) nib = disp[4*k +: 4];
        end
    end

    // zhi[k]: every nibble from the top down to k is zero
    always_comb begin
        zhi = '0;
        acc = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            acc    = acc & (disp[4*k +: 4] == 4'd0);
            zhi[k] = acc;
        end
    end

    seg7 u_dec (
        .nib (nib),
        .seg (dec)
    );

    always_comb begin
        sup   = bus.lz_en && (nidx != '0) && zhi[nidx];
        an_n  = '0;
        seg_n = 7'b0000000;
        if (nstate == SHOW) begin
            an_n  = DIGITS'(1) << nidx;
            seg_n = sup ? 7'b0000000 : dec;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            run        <= 1'b0;
            shadow     <= '0;
            disp       <= '0;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
            an         <= '0;
            seg        <= 7'b0000000;
        end else begin
            state      <= nstate;
            cnt        <= ncnt;
            idx        <= nidx;
            run        <= 1'b1;
            frame_tick <= bnd;
            an         <= an_n;
            seg        <= seg_n;
            if (bnd) begin
                pending <= 1'b0;
                if (bus.load) disp <= bus.data_in;
                else if (pending) disp <= shadow;
            end else if (bus.load) begin
                shadow  <= bus.data_in;
                pending <= 1'b1;
            end
        end
    end

    assign bus.seg        = seg;
    assign bus.an         = an;
    assign bus.pending    = pending;
    assign bus.frame_tick = frame_tick;
endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: directed scenarios plus random loads, every cycle
// compared against a frame-position model of the display timeline.
module tb_seg7_scan;
    localparam int DIGITS = 4;
    localparam int RDIV   = 8;
    localparam int BLANK  = 2;
    localparam int DPER   = RDIV + BLANK;
    localparam int FRAME  = DIGITS * DPER;

    logic clk = 1'b0;
    logic rst_n;
    int   nvec = 0;
    int   nerr = 0;

    int          e = 0;
    logic [15:0] mdisp = '0;
    logic [15:0] msh = '0;
    logic        mpend = 1'b0;

    logic [6:0] rom [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    seg7_scan_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan #(
        .DIGITS       (DIGITS),
        .REFRESH_DIV  (RDIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] digit_seg(input int dg);
        logic [15:0] hi;
        hi = mdisp >> (4 * dg);
        if (bus.lz_en && dg != 0 && hi == 16'd0) return 7'b0000000;
        return rom[hi[3:0]];
    endfunction

    task automatic tick(input logic ld, input logic [15:0] d);
        logic [3:0] an_x;
        logic [6:0] seg_x;
        logic       tk_x;
        int         pos, dg, w;
        bus.load    = ld;
        bus.data_in = d;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        an_x  = '0;
        seg_x = '0;
        tk_x  = 1'b0;
        if (!rst_n) begin
            mdisp = '0;
            msh   = '0;
            mpend = 1'b0;
            e     = 0;
        end else begin
            pos  = e % FRAME;
            dg   = pos / DPER;
            w    = pos % DPER;
            tk_x = (pos == 0);
            if (tk_x) begin
                if (ld) mdisp = d;
                else if (mpend) mdisp = msh;
                mpend = 1'b0;
            end else if (ld) begin
                msh   = d;
                mpend = 1'b1;
            end
            if (w >= BLANK) begin
                an_x  = 4'(1 << dg);
                seg_x = digit_seg(dg);
            end
            e++;
        end
        nvec++;
        assert (bus.an === an_x) else begin
            nerr++;
            $error("FAIL an e=%0d got %b want %b", e, bus.an, an_x);
        end
        nvec++;
        assert (bus.seg === seg_x) else begin
            nerr++;
            $error("FAIL seg e=%0d got %b want %b", e, bus.seg, seg_x);
        end
        nvec++;
        assert (bus.pending === mpend) else begin
            nerr++;
            $error("FAIL pending e=%0d got %b want %b", e, bus.pending, mpend);
        end
        nvec++;
        assert (bus.frame_tick === tk_x) else begin
            nerr++;
            $error("FAIL tick e=%0d got %b want %b", e, bus.frame_tick, tk_x);
        end
        nvec++;
        assert ($onehot0(bus.an)) else begin
            nerr++;
            $error("FAIL onehot e=%0d got %b want onehot0", e, bus.an);
        end
    endtask

    task automatic spot(input string tag, input logic [7:0] got, input logic [7:0] want);
        nvec++;
        assert (got === want) else begin
            nerr++;
            $error("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    task automatic run_to(input int p);
        for (int i = 0; i < FRAME + 1 && (e % FRAME) != p; i++) tick(1'b0, 16'h0);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.load    = 1'b0;
        bus.data_in = '0;
        bus.lz_en   = 1'b0;

        tick(1'b1, 16'hBEEF);
        tick(1'b0, 16'h0);
        spot("rst_an", 8'(bus.an), 8'h00);
        spot("rst_pend", 8'(bus.pending), 8'h00);
        rst_n = 1'b1;

        // 1: load in cycle 3, shown in the frame starting at edge 40
        tick(1'b0, 16'h0);
        spot("tick0", 8'(bus.frame_tick), 8'h01);
        tick(1'b0, 16'h0);
        tick(1'b0, 16'h0);
        spot("first_d0", 8'(bus.seg), 8'h7E);
        tick(1'b1, 16'h1058);
        spot("pend_set", 8'(bus.pending), 8'h01);
        run_to(0);
        tick(1'b0, 16'h0);
        spot("pend_clr", 8'(bus.pending), 8'h00);
        run_to(3);
        spot("d0_8", 8'(bus.seg), 8'h7F);
        spot("d0_an", 8'(bus.an), 8'h01);
        run_to(33);
        spot("d3_1", 8'(bus.seg), 8'h30);
        spot("d3_an", 8'(bus.an), 8'h08);

        // 2: leading-zero suppression
        bus.lz_en = 1'b1;
        tick(1'b1, 16'h0007);
        run_to(0);
        tick(1'b0, 16'h0);
        run_to(3);
        spot("lz_d0", 8'(bus.seg), 8'h70);
        run_to(23);
        spot("lz_d2", 8'(bus.seg), 8'h00);
        spot("lz_d2an", 8'(bus.an), 8'h04);
        bus.lz_en = 1'b0;
        run_to(33);
        spot("nolz_d3", 8'(bus.seg), 8'h7E);

        // 3: last load in a frame wins
        run_to(5);
        tick(1'b1, 16'h1111);
        tick(1'b0, 16'h0);
        tick(1'b1, 16'h2222);
        run_to(0);
        tick(1'b0, 16'h0);
        run_to(13);
        spot("lastwin", 8'(bus.seg), 8'h6D);

        // 4: load on the boundary cycle goes straight to display
        run_to(0);
        tick(1'b1, 16'h3333);
        spot("bnd_pend", 8'(bus.pending), 8'h00);
        spot("bnd_tick", 8'(bus.frame_tick), 8'h01);
        run_to(3);
        spot("bnd_d0", 8'(bus.seg), 8'h79);

        // 5: reset mid-SHOW of digit 2
        run_to(25);
        rst_n = 1'b0;
        tick(1'b0, 16'h0);
        spot("mrst_an", 8'(bus.an), 8'h00);
        spot("mrst_seg", 8'(bus.seg), 8'h00);
        rst_n = 1'b1;
        tick(1'b0, 16'h0);
        spot("mrst_tick", 8'(bus.frame_tick), 8'h01);
        tick(1'b0, 16'h0);
        tick(1'b0, 16'h0);
        spot("mrst_d0", 8'(bus.seg), 8'h7E);
        run_to(0);

        // 6: random loads over ten frames
        for (int i = 0; i < 10 * FRAME; i++) begin
            if ($urandom_range(0, 31) == 0) bus.lz_en = ~bus.lz_en;
            tick($urandom_range(0, 15) == 0, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed scan controller for a DIGITS-wide common-bus 7-segment display. It shares one internal `seg7` decoder across all digits. The controller holds a frame of BCD/hex nibbles and steps a one-hot digit enable through them at a fixed refresh rate. A blanking gap between digits prevents ghosting. New frames are accepted through a load interface and applied only at frame boundaries, so the display never shows a mix of old and new digits.

## Interface
- DIGITS, 4: number of digits scanned; legal range 2–8.
- REFRESH_DIV, 1000: clock cycles each digit stays lit; at least 1.
- BLANK_CYCLES, 2: clock cycles with all digits off before each digit; at least 1.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- load  in  1  one-cycle strobe that captures data_in.
- data_in  in  4*DIGITS  nibble k = data_in[4k+3:4k] is digit k; digit 0 is least significant.
- lz_en  in  1  enables leading-zero suppression; sampled every cycle.
- seg  out  7  segment drive, active-high; seg[6..0] = a,b,c,d,e,f,g.
- an  out  DIGITS  one-hot digit enable, active-high; all-zero while blanking.
- pending  out  1  a captured frame is waiting for the next frame boundary.
- frame_tick  out  1  one-cycle pulse when digit 0 begins its blank phase.

## Operation
- Contains one `seg7` instance. Its input is the current digit's nibble from the display register, and its output is registered into `seg`.
- Storage:
  - shadow register, 4*DIGITS bits
  - display register, 4*DIGITS bits
  - digit index `idx`, width clog2(DIGITS)
  - phase counter `cnt`
  - FSM with 2 states
- FSM states:
  - BLANK: an = 0, seg = 0. Lasts BLANK_CYCLES cycles, then goes to SHOW.
  - SHOW: an = one-hot(idx), seg = decoded nibble[idx]. Lasts REFRESH_DIV cycles, then goes to BLANK.
  - On the SHOW→BLANK transition, idx advances by one and wraps from DIGITS-1 to 0.
- Frame boundary: the transition into BLANK with idx = 0. This includes the first cycle after reset release.
  - frame_tick = 1 for that single cycle.
  - If pending = 1, the shadow register is copied to the display register and pending clears.
- Load:
  - load = 1 copies data_in into the shadow register and sets pending = 1.
  - A load while pending = 1 overwrites the shadow register; the last load wins and nothing is queued.
  - A load on the frame-boundary cycle writes data_in directly to the display register. pending stays 0 and the new frame is shown in that same frame.
- Leading-zero suppression (lz_en = 1): digit k is suppressed when nibbles DIGITS-1 down to k are all 0 and k ≠ 0.
  - A suppressed digit drives seg = 0 during its SHOW phase; an is still asserted normally.
  - Digit 0 is never suppressed.
- Nibble values 10–15 are decoded by `seg7` unchanged. The controller does not check them.
- Reset (rst_n = 0 on any clock edge, including mid-frame) sets:
  - seg = 0, an = 0, pending = 0, frame_tick = 0
  - idx = 0, cnt = 0, state = BLANK
  - shadow and display registers = 0
  - A load in a reset cycle is ignored.

## Timing
- All outputs are registered and free of glitches. an and seg change on the same edge.
- Digit period = BLANK_CYCLES + REFRESH_DIV cycles. Frame period = DIGITS × digit period.
- Cycle 0 is the first edge with rst_n = 1:
  - frame_tick = 1 and the FSM is in BLANK for digit 0.
  - Digit 0 first shows at edge BLANK_CYCLES.
- Load-to-display latency:
  - Minimum: 0 cycles (load on the frame-boundary cycle).
  - Maximum: frame period − 1 cycles before the new frame is in the display register.
  - The first SHOW of digit 0 then follows BLANK_CYCLES cycles later.
- an is never non-zero on two consecutive digits without at least BLANK_CYCLES all-zero cycles between them.

## Test plan
Bench parameters: DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, giving a 40-cycle frame.

1. Reset, then load data_in=16'h1058 in cycle 3. Required:
   - pending goes 1, then 0 at the cycle-40 frame_tick.
   - The following frame shows seg=7'b1111111 with an=0001, 7'b1011011 with an=0010, 7'b1111110 with an=0100, 7'b0110000 with an=1000.
   - Each digit is lit for 8 cycles and preceded by 2 cycles of an=0 and seg=0.
2. lz_en=1, data_in=16'h0007. Required: digits 3 and 2 give seg=0 with an still asserted; digit 1 gives seg=0; digit 0 gives seg=7'b1110000. Set lz_en=0: digits 3–1 give 7'b1111110.
3. Load 16'h1111, then 16'h2222 two cycles later within the same frame. Required: the next frame shows only 2s, and 1s never appear.
4. Load 16'h3333 on the exact frame_tick cycle. Required: the 3s appear in that same frame, and pending never rises.
5. Assert rst_n=0 mid-SHOW of digit 2 for one cycle. Required:
   - The next edge gives an=0, seg=0, pending=0, and the display register cleared.
   - After release, frame_tick fires immediately and digit 0 shows 7'b1111110 at +2 cycles.
6. Run 10 frames with random loads. Required:
   - an is always one-hot or zero.
   - frame_tick occurs exactly every 40 cycles.
   - Each displayed frame equals exactly one loaded data_in value.
